// File: rtl/mult4_seq_if.sv
// Request/result bus between mult4_seq and the block that launches multiplies
// and owns the downstream nibble registers.
interface mult4_seq_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       ld;
    logic [3:0] p_hi;
    logic [3:0] p_lo;

    modport master (
        output start, a, b,
        input  busy, done, ld, p_hi, p_lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, ld, p_hi, p_lo
    );
endinterface

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier: one partial product per clock,
// result presented as registered nibbles with a one-cycle load strobe.
module mult4_seq (
    input  logic       cl,
    input  logic       rst,
    mult4_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state;
    state_e     state_nxt;

    logic [3:0] reg_m;
    logic [3:0] reg_q;
    logic [3:0] reg_a;
    logic       reg_c;
    logic [1:0] cnt;
    logic [3:0] p_hi_q;
    logic [3:0] p_lo_q;

    logic [4:0] sum;
    logic [8:0] shifted;

    // State register
    always_ff @(posedge cl) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at while idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (cnt == 2'd3) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are pure decodes of the registered state
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.ld   = 1'b0;
        case (state)
            RUN:  bus.busy = 1'b1;
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                bus.ld   = 1'b1;
            end
            default: ;
        endcase
    end

    // One add-and-shift step; the 9-bit shift of {S,Q} drops the consumed multiplier bit
    always_comb begin
        sum     = {reg_c, reg_a} + (reg_q[0] ? {1'b0, reg_m} : 5'd0);
        shifted = {sum, reg_q} >> 1;
    end

    // Datapath and result registers
    always_ff @(posedge cl) begin
        if (rst) begin
            reg_m  <= 4'd0;
            reg_q  <= 4'd0;
            reg_a  <= 4'd0;
            reg_c  <= 1'b0;
            cnt    <= 2'd0;
            p_hi_q <= 4'd0;
            p_lo_q <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        reg_m <= bus.a;
                        reg_q <= bus.b;
                        reg_a <= 4'd0;
                        reg_c <= 1'b0;
                        cnt   <= 2'd0;
                    end
                end
                RUN: begin
                    reg_c <= shifted[8];
                    reg_a <= shifted[7:4];
                    reg_q <= shifted[3:0];
                    cnt   <= cnt + 2'd1;
                    // Whole product lands at once on the final iteration
                    if (cnt == 2'd3) begin
                        p_hi_q <= shifted[7:4];
                        p_lo_q <= shifted[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p_hi = p_hi_q;
    assign bus.p_lo = p_lo_q;

endmodule

// File: tb/tb_mult4_seq.sv
// Directed self-checking bench for mult4_seq: reset, corner products,
// start hold/ignore, mid-operation reset and a back-to-back 256-pair sweep.
module tb_mult4_seq;

    logic cl;
    logic rst;
    int   checks;
    int   failures;
    int   cycle;

    mult4_seq_if bus_if ();

    mult4_seq dut (
        .cl  (cl),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial cl = 1'b0;
    always #5 cl = ~cl;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge cl);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic st);
        bus_if.a     = av;
        bus_if.b     = bv;
        bus_if.start = st;
    endtask

    // Launch one multiply from idle and check latency, strobes and result
    task automatic runOp(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] expp, input string tag);
        int lat;
        bit seen;
        applyStimulus(av, bv, 1'b1);
        step();
        applyStimulus(4'd0, 4'd0, 1'b0);
        checkOutput({tag, "_busy_e0"}, bus_if.busy, 1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            step();
            lat++;
            if (bus_if.ld) seen = 1;
        end
        checkOutput({tag, "_latency"}, lat, 4);
        checkOutput({tag, "_done"}, bus_if.done, 1);
        checkOutput({tag, "_busy_e4"}, bus_if.busy, 1);
        checkOutput({tag, "_product"}, {bus_if.p_hi, bus_if.p_lo}, expp);
        step();
        checkOutput({tag, "_ld_e5"}, {bus_if.ld, bus_if.done, bus_if.busy}, 0);
        checkOutput({tag, "_hold_e5"}, {bus_if.p_hi, bus_if.p_lo}, expp);
    endtask

    initial begin
        int ldcount;
        int lastld;
        logic [3:0] na;
        logic [3:0] nb;
        checks   = 0;
        failures = 0;
        cycle    = 0;
        rst      = 1'b1;
        applyStimulus(4'd0, 4'd0, 1'b0);

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("reset_idle", {bus_if.busy, bus_if.done, bus_if.ld, bus_if.p_hi, bus_if.p_lo}, 0);
        end

        // Corner products
        runOp(4'd3, 4'd5, 8'h0F, "basic");
        runOp(4'd15, 4'd15, 8'hE1, "max");
        runOp(4'd0, 4'd9, 8'h00, "zero");

        // Start held high: operands changed in flight, start at E5 ignored, next accept at E6
        applyStimulus(4'd7, 4'd6, 1'b1);
        step();
        checkOutput("hold_busy_e0", bus_if.busy, 1);
        step();
        applyStimulus(4'd2, 4'd3, 1'b1);
        step();
        step();
        step();
        checkOutput("hold_ld_e4", bus_if.ld, 1);
        checkOutput("hold_first", {bus_if.p_hi, bus_if.p_lo}, 8'h2A);
        step();
        checkOutput("hold_busy_e5", {bus_if.busy, bus_if.ld}, 0);
        step();
        checkOutput("hold_busy_e6", bus_if.busy, 1);
        applyStimulus(4'd0, 4'd0, 1'b0);
        for (int i = 7; i <= 9; i++) begin
            step();
            checkOutput("hold_keep", {bus_if.ld, bus_if.p_hi, bus_if.p_lo}, {1'b0, 8'h2A});
        end
        step();
        checkOutput("hold_ld_second", bus_if.ld, 1);
        checkOutput("hold_second", {bus_if.p_hi, bus_if.p_lo}, 8'h06);
        step();

        // Reset asserted so it is sampled at E2 aborts the operation
        applyStimulus(4'd9, 4'd9, 1'b1);
        step();
        applyStimulus(4'd0, 4'd0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_clear", {bus_if.busy, bus_if.done, bus_if.ld, bus_if.p_hi, bus_if.p_lo}, 0);
        ldcount = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_if.ld || bus_if.busy) ldcount++;
        end
        checkOutput("abort_no_ld", ldcount, 0);
        runOp(4'd2, 4'd4, 8'h08, "after_abort");

        // Exhaustive back-to-back sweep with start held high
        ldcount = 0;
        lastld  = -1;
        applyStimulus(4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] expp;
            na   = k[7:4];
            nb   = k[3:0];
            expp = na * nb;
            step();
            if (k < 255) begin
                na = (k + 1) >> 4;
                nb = (k + 1) & 15;
                applyStimulus(na, nb, 1'b1);
            end else begin
                applyStimulus(4'd0, 4'd0, 1'b0);
            end
            for (int c = 1; c <= 5; c++) begin
                step();
                if (bus_if.ld) begin
                    ldcount++;
                    checkOutput("sweep_product", {bus_if.p_hi, bus_if.p_lo}, expp);
                    if (lastld >= 0) checkOutput("sweep_spacing", cycle - lastld, 6);
                    lastld = cycle;
                end
            end
        end
        checkOutput("sweep_ld_count", ldcount, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
